// File: rtl/cr_crc_sched_pkg.sv
// cr_crc_sched_pkg: shared types and constants for the CRC frame scheduler.
//   state_t  - scheduler FSM states
//   *_DEF    - default engine widths and init value
//   id_width - bit width of a requester index for a given requester count
package cr_crc_sched_pkg;

  typedef enum logic [1:0] {IDLE, INIT, DATA, DONE} state_t;

  localparam int          DATA_W_DEF     = 64;
  localparam int          CRC_W_DEF      = 32;
  localparam int          VBYTES_W       = 8;
  localparam logic [31:0] INIT_VALUE_DEF = 32'hFFFF_FFFF;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cr_crc_sched_rr_arb.sv
// cr_crc_sched_rr_arb: round-robin picker over N_REQ request lines.
//   clk, rst : clock, synchronous active-high reset (pointer back to 0)
//   i_req    : request vector
//   i_upd    : accept the current pick; pointer moves to pick+1 (mod N_REQ)
//   o_gnt    : index of the first requester at or after the pointer
//   o_any    : at least one request is present
module cr_crc_sched_rr_arb
  import cr_crc_sched_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              i_req,
  input  logic                          i_upd,
  output logic [id_width(N_REQ)-1:0]    o_gnt,
  output logic                          o_any
);

  localparam int ID_W = id_width(N_REQ);

  logic [ID_W-1:0] r_ptr;
  int              w_idx;

  // Scan offsets from the far end down so the nearest candidate wins last.
  always_comb begin
    o_gnt = '0;
    o_any = 1'b0;
    w_idx = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = (int'(r_ptr) + k) % N_REQ;
      if (i_req[w_idx[ID_W-1:0]]) begin
        o_gnt = w_idx[ID_W-1:0];
        o_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_upd) begin
      r_ptr <= (o_gnt == ID_W'(N_REQ - 1)) ? '0 : o_gnt + 1'b1;
    end
  end

endmodule

// File: rtl/cr_crc_sched.sv
// cr_crc_sched: shares one CRC engine among N_REQ frame sources.
// A frame is granted round-robin on its sof beat, the engine is initialised
// for one cycle, beats of the granted requester are forwarded until eof, and
// the final CRC is then offered on res_* with a valid/ready handshake.
//   clk, rst          : clock, synchronous active-high reset
//   req_*             : per-requester beat stream (slice i = requester i)
//   res_*             : result handshake (crc, owning id, abort flag)
//   crc_*             : connection to the external CRC engine
// Optional build macro CR_CRC_SCHED_TIMEOUT_EN: aborts a frame whose granted
// requester stalls mid-frame for TIMEOUT_CYCLES cycles (res_err=1, res_crc=0).
// Without it res_err is tied 0 and a stalled frame waits indefinitely.
module cr_crc_sched
  import cr_crc_sched_pkg::*;
#(
  parameter int                     N_REQ          = 4,
  parameter int                     N_DATA_WIDTH   = DATA_W_DEF,
  parameter int                     N_CRC_WIDTH    = CRC_W_DEF,
  parameter logic [N_CRC_WIDTH-1:0] INIT_VALUE     = N_CRC_WIDTH'(INIT_VALUE_DEF),
  parameter int                     TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ-1:0]              req_sof,
  input  logic [N_REQ-1:0]              req_eof,
  input  logic [N_REQ*N_DATA_WIDTH-1:0] req_data,
  input  logic [N_REQ*8-1:0]            req_vbytes,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [N_CRC_WIDTH-1:0]        res_crc,
  output logic [id_width(N_REQ)-1:0]    res_id,
  output logic                          res_err,
  output logic                          crc_init,
  output logic [N_CRC_WIDTH-1:0]        crc_init_value,
  output logic                          crc_data_valid,
  output logic [N_DATA_WIDTH-1:0]       crc_data_in,
  output logic [7:0]                    crc_data_vbytes,
  output logic                          crc_enable,
  input  logic [N_CRC_WIDTH-1:0]        crc_value
);

  localparam int ID_W = id_width(N_REQ);

  state_t                  r_state;
  logic [ID_W-1:0]         r_gnt;
  logic [ID_W-1:0]         w_arb_gnt;
  logic                    w_any;
  logic                    w_upd;
  logic [N_REQ-1:0]        w_cand;
  logic                    w_valid;
  logic                    w_eof;
  logic [N_DATA_WIDTH-1:0] w_data;
  logic [7:0]              w_vbytes;
  logic                    w_in_data;
  logic                    w_in_done;
  logic                    w_accept;

  // Only a sof beat can open a frame; stray mid-frame beats never win.
  assign w_cand = req_valid & req_sof;
  assign w_upd  = (r_state == IDLE) & w_any;

  cr_crc_sched_rr_arb #(
    .N_REQ (N_REQ)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_req (w_cand),
    .i_upd (w_upd),
    .o_gnt (w_arb_gnt),
    .o_any (w_any)
  );

  assign w_valid  = req_valid[r_gnt];
  assign w_eof    = req_eof[r_gnt];
  assign w_data   = req_data[r_gnt*N_DATA_WIDTH +: N_DATA_WIDTH];
  assign w_vbytes = req_vbytes[r_gnt*8 +: 8];

  assign w_in_data = (r_state == DATA);
  assign w_in_done = (r_state == DONE);
  assign w_accept  = w_in_data & w_valid;

  assign req_ready       = w_in_data ? (N_REQ'(1) << r_gnt) : '0;
  assign crc_init        = (r_state == INIT);
  assign crc_init_value  = INIT_VALUE;
  assign crc_data_valid  = w_accept;
  assign crc_data_in     = w_in_data ? w_data : '0;
  assign crc_data_vbytes = w_in_data ? w_vbytes : '0;
  // The engine sees neither init nor data in DONE, so its value is stable.
  assign crc_enable      = w_in_done;
  assign res_valid       = w_in_done;
  assign res_id          = w_in_done ? r_gnt : '0;

`ifdef CR_CRC_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TO_W-1:0] r_stall;
  logic            r_err;
  logic            w_timeout;

  assign w_timeout = (r_stall == TO_W'(TIMEOUT_CYCLES - 1));
  assign res_err   = w_in_done & r_err;
  assign res_crc   = (w_in_done & ~r_err) ? crc_value : '0;
`else
  assign res_err   = 1'b0;
  assign res_crc   = w_in_done ? crc_value : '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
`ifdef CR_CRC_SCHED_TIMEOUT_EN
      r_stall <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt   <= w_arb_gnt;
            r_state <= INIT;
          end
        end
        INIT: begin
          r_state <= DATA;
`ifdef CR_CRC_SCHED_TIMEOUT_EN
          r_stall <= '0;
          r_err   <= 1'b0;
`endif
        end
        DATA: begin
          if (w_accept && w_eof) r_state <= DONE;
`ifdef CR_CRC_SCHED_TIMEOUT_EN
          if (w_accept) begin
            r_stall <= '0;
          end else if (w_timeout) begin
            r_state <= DONE;
            r_err   <= 1'b1;
          end else begin
            r_stall <= r_stall + 1'b1;
          end
`endif
        end
        DONE: begin
          if (res_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Only the closing beat of a frame may carry a partial byte mask.
  a_full_mid_beats: assert property (@(posedge clk) disable iff (rst)
    (w_accept && !w_eof) |-> (w_vbytes == 8'hFF));

endmodule

// File: tb/tb_cr_crc_sched.sv
module tb_cr_crc_sched;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int CW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_sof, req_eof;
  logic [N*DW-1:0] req_data;
  logic [N*8-1:0]  req_vbytes;
  logic            res_valid, res_ready, res_err;
  logic [CW-1:0]   res_crc;
  logic [1:0]      res_id;
  logic            crc_init, crc_data_valid, crc_enable;
  logic [CW-1:0]   crc_init_value, crc_value, eng_crc;
  logic [DW-1:0]   crc_data_in;
  logic [7:0]      crc_data_vbytes;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cr_crc_sched #(
    .N_REQ          (N),
    .N_DATA_WIDTH   (DW),
    .N_CRC_WIDTH    (CW),
    .INIT_VALUE     (32'hFFFF_FFFF),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_sof         (req_sof),
    .req_eof         (req_eof),
    .req_data        (req_data),
    .req_vbytes      (req_vbytes),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_crc         (res_crc),
    .res_id          (res_id),
    .res_err         (res_err),
    .crc_init        (crc_init),
    .crc_init_value  (crc_init_value),
    .crc_data_valid  (crc_data_valid),
    .crc_data_in     (crc_data_in),
    .crc_data_vbytes (crc_data_vbytes),
    .crc_enable      (crc_enable),
    .crc_value       (crc_value)
  );

  // Reflected CRC-32, bytes taken low lane first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] crc_beat(input logic [31:0] c, input logic [63:0] d,
                                           input logic [7:0] vb);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 8; k++) if (vb[k]) r = crc_byte(r, d[8*k +: 8]);
    return r;
  endfunction

  // Engine stand-in driven only by the scheduler's crc_* outputs.
  always @(posedge clk) begin
    if (crc_init) eng_crc <= crc_init_value;
    else if (crc_data_valid) eng_crc <= crc_beat(eng_crc, crc_data_in, crc_data_vbytes);
  end
  assign crc_value = eng_crc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid  = '0;
    req_sof    = '0;
    req_eof    = '0;
    req_data   = '0;
    req_vbytes = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    res_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Runs a frame assumed to be granted straight away; returns in DONE.
  task automatic drive_frame(input int id, input int nb, input logic [7:0] last_vb,
                             input logic [63:0] base, output logic [31:0] exp);
    logic [63:0] d;
    logic [7:0]  v;
    exp = 32'hFFFF_FFFF;
    for (int k = 0; k < nb; k++) begin
      d = base + 64'(k);
      v = (k == nb - 1) ? last_vb : 8'hFF;
      exp = crc_beat(exp, d, v);
      req_valid[id] = 1'b1;
      req_sof[id]   = (k == 0);
      req_eof[id]   = (k == nb - 1);
      req_data[id*DW +: DW]  = d;
      req_vbytes[id*8 +: 8]  = v;
      if (k == 0) begin
        tick();
        tick();
      end
      tick();
    end
    req_valid[id] = 1'b0;
    req_sof[id]   = 1'b0;
    req_eof[id]   = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    tick();
    n_vec++;
    if ({req_ready, res_valid, crc_init, crc_data_valid, crc_enable, res_err} !== '0) begin
      n_err++;
      $display("FAIL reset_ctrl: got rdy=%b rv=%b init=%b dv=%b en=%b err=%b, want all 0",
               req_ready, res_valid, crc_init, crc_data_valid, crc_enable, res_err);
    end
    n_vec++;
    if ({res_crc, res_id, crc_data_in, crc_data_vbytes} !== '0) begin
      n_err++;
      $display("FAIL reset_data: got crc=%h id=%0d din=%h vb=%h, want 0",
               res_crc, res_id, crc_data_in, crc_data_vbytes);
    end
    n_vec++;
    if (crc_init_value !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL reset_init_value: got %h want ffffffff", crc_init_value);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_frame();
    logic [63:0] d[3];
    logic [7:0]  vb[3];
    logic [31:0] exp;
    d[0] = 64'h0123_4567_89AB_CDEF;
    d[1] = 64'hFEDC_BA98_7654_3210;
    d[2] = 64'h0000_0000_DEAD_BEEF;
    vb[0] = 8'hFF; vb[1] = 8'hFF; vb[2] = 8'h0F;
    exp = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) exp = crc_beat(exp, d[k], vb[k]);

    req_valid[2] = 1'b1;
    req_sof[2]   = 1'b1;
    req_data[2*DW +: DW] = d[0];
    req_vbytes[16 +: 8]  = vb[0];
    #1;
    n_vec++;
    if ({req_ready, crc_init} !== 5'b0) begin
      n_err++;
      $display("FAIL sf_idle: got rdy=%b init=%b want 0000/0", req_ready, crc_init);
    end
    tick();
    n_vec++;
    if ({crc_init, crc_data_valid, req_ready} !== 6'b10_0000) begin
      n_err++;
      $display("FAIL sf_init: got init=%b dv=%b rdy=%b want 1/0/0000",
               crc_init, crc_data_valid, req_ready);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        req_sof[2] = 1'b0;
        req_eof[2] = (k == 2);
        req_data[2*DW +: DW] = d[k];
        req_vbytes[16 +: 8]  = vb[k];
        #1;
      end
      n_vec++;
      if ({crc_data_valid, crc_init, req_ready, crc_data_in, crc_data_vbytes} !==
          {1'b1, 1'b0, 4'b0100, d[k], vb[k]}) begin
        n_err++;
        $display("FAIL sf_beat%0d: got dv=%b init=%b rdy=%b din=%h vb=%h want 1/0/0100/%h/%h",
                 k, crc_data_valid, crc_init, req_ready, crc_data_in, crc_data_vbytes,
                 d[k], vb[k]);
      end
      tick();
    end
    clear_inputs();
    #1;
    n_vec++;
    if ({res_valid, crc_enable, res_err, res_id, res_crc} !== {1'b1, 1'b1, 1'b0, 2'd2, exp}) begin
      n_err++;
      $display("FAIL sf_result: got rv=%b en=%b err=%b id=%0d crc=%h want 1/1/0/2/%h",
               res_valid, crc_enable, res_err, res_id, res_crc, exp);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_vec++;
    if (res_valid !== 1'b0) begin
      n_err++;
      $display("FAIL sf_after_hs: got res_valid=%b want 0", res_valid);
    end
  endtask

  // One single-beat frame in a round-robin sequence; the grant must be exp.
  task automatic rr_frame(input int exp);
    logic [3:0] m;
    m = 4'b0001 << exp;
    #1;
    n_vec++;
    if (req_ready !== 4'b0) begin
      n_err++;
      $display("FAIL rr_idle_ready: got %b want 0000", req_ready);
    end
    tick();
    tick();
    n_vec++;
    if (req_ready !== m) begin
      n_err++;
      $display("FAIL rr_grant: got req_ready=%b want %b", req_ready, m);
    end
    tick();
    req_valid[exp] = 1'b0;
    req_sof[exp]   = 1'b0;
    req_eof[exp]   = 1'b0;
    #1;
    n_vec++;
    if ({res_valid, res_id} !== {1'b1, 2'(exp)}) begin
      n_err++;
      $display("FAIL rr_res_id: got rv=%b id=%0d want 1/%0d", res_valid, res_id, exp);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) begin
      if (i != 2) begin
        req_valid[i] = 1'b1;
        req_sof[i]   = 1'b1;
        req_eof[i]   = 1'b1;
        req_data[i*DW +: DW] = 64'(i + 16);
        req_vbytes[i*8 +: 8] = 8'hFF;
      end
    end
    rr_frame(0);
    rr_frame(1);
    rr_frame(3);
    req_valid = 4'b1001;
    req_sof   = 4'b1001;
    req_eof   = 4'b1001;
    rr_frame(0);
    clear_inputs();
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    // Requester 0 waits with a sof beat while requester 1 (pointer 1) wins.
    req_valid[0] = 1'b1;
    req_sof[0]   = 1'b1;
    req_eof[0]   = 1'b1;
    req_data[0 +: DW] = 64'h55;
    req_vbytes[0 +: 8] = 8'h03;
    drive_frame(1, 2, 8'h3F, 64'hA5A5_0000_1234_0000, exp);
    for (int c = 0; c < 10; c++) begin
      n_vec++;
      if ({res_valid, res_id, res_crc, req_ready} !== {1'b1, 2'd1, exp, 4'b0}) begin
        n_err++;
        $display("FAIL bp_hold%0d: got rv=%b id=%0d crc=%h rdy=%b want 1/1/%h/0000",
                 c, res_valid, res_id, res_crc, req_ready, exp);
      end
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_vec++;
    if ({res_valid, crc_init, req_ready} !== 6'b0) begin
      n_err++;
      $display("FAIL bp_post_hs: got rv=%b init=%b rdy=%b want 0/0/0000",
               res_valid, crc_init, req_ready);
    end
    tick();
    n_vec++;
    if (crc_init !== 1'b1) begin
      n_err++;
      $display("FAIL bp_next_grant: got crc_init=%b want 1", crc_init);
    end
    tick();
    n_vec++;
    if (req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL bp_next_ready: got %b want 0001", req_ready);
    end
    tick();
    clear_inputs();
    #1;
    n_vec++;
    if ({res_valid, res_id, res_crc} !== {1'b1, 2'd0, crc_beat(32'hFFFF_FFFF, 64'h55, 8'h03)}) begin
      n_err++;
      $display("FAIL bp_next_result: got rv=%b id=%0d crc=%h want 1/0/%h", res_valid, res_id,
               res_crc, crc_beat(32'hFFFF_FFFF, 64'h55, 8'h03));
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_single_beat();
    logic [31:0] exp;
    exp = crc_beat(32'hFFFF_FFFF, 64'h0000_0000_0000_00AB, 8'h01);
    req_valid[3] = 1'b1;
    req_sof[3]   = 1'b1;
    req_eof[3]   = 1'b1;
    req_data[3*DW +: DW] = 64'h0000_0000_0000_00AB;
    req_vbytes[24 +: 8]  = 8'h01;
    #1;
    n_vec++;
    if (res_valid !== 1'b0) begin
      n_err++;
      $display("FAIL sb_t0: got res_valid=%b want 0", res_valid);
    end
    tick();
    n_vec++;
    if ({crc_init, res_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL sb_t1: got init=%b rv=%b want 1/0", crc_init, res_valid);
    end
    tick();
    n_vec++;
    if ({crc_data_valid, crc_data_vbytes, res_valid} !== {1'b1, 8'h01, 1'b0}) begin
      n_err++;
      $display("FAIL sb_t2: got dv=%b vb=%h rv=%b want 1/01/0",
               crc_data_valid, crc_data_vbytes, res_valid);
    end
    tick();
    clear_inputs();
    #1;
    n_vec++;
    if ({res_valid, res_id, res_crc} !== {1'b1, 2'd3, exp}) begin
      n_err++;
      $display("FAIL sb_t3: got rv=%b id=%0d crc=%h want 1/3/%h", res_valid, res_id, res_crc, exp);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] exp;
    req_valid[0] = 1'b1;
    req_sof[0]   = 1'b1;
    req_data[0 +: DW]  = 64'h1111_2222_3333_4444;
    req_vbytes[0 +: 8] = 8'hFF;
    tick();
    tick();
    tick();
    req_sof[0] = 1'b0;
    req_data[0 +: DW] = 64'h5555_6666_7777_8888;
    #1;
    n_vec++;
    if ({crc_data_valid, req_ready} !== 5'b1_0001) begin
      n_err++;
      $display("FAIL rm_in_data: got dv=%b rdy=%b want 1/0001", crc_data_valid, req_ready);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if ({req_ready, res_valid, crc_init, crc_data_valid, crc_enable, crc_data_in, res_crc} !== '0) begin
      n_err++;
      $display("FAIL rm_after_rst: got rdy=%b rv=%b init=%b dv=%b en=%b din=%h crc=%h want 0",
               req_ready, res_valid, crc_init, crc_data_valid, crc_enable, crc_data_in, res_crc);
    end
    tick();
    tick();
    tick();
    n_vec++;
    if ({req_ready, crc_init, res_valid} !== 6'b0) begin
      n_err++;
      $display("FAIL rm_leftover_idle: got rdy=%b init=%b rv=%b want 0", req_ready, crc_init,
               res_valid);
    end
    drive_frame(1, 3, 8'h07, 64'h0F0E_0D0C_0B0A_0908, exp);
    n_vec++;
    if ({res_valid, res_id, res_crc} !== {1'b1, 2'd1, exp}) begin
      n_err++;
      $display("FAIL rm_next_frame: got rv=%b id=%0d crc=%h want 1/1/%h",
               res_valid, res_id, res_crc, exp);
    end
    clear_inputs();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

`ifdef CR_CRC_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    req_valid[0] = 1'b1;
    req_sof[0]   = 1'b1;
    req_data[0 +: DW]  = 64'hCAFE;
    req_vbytes[0 +: 8] = 8'hFF;
    tick();
    tick();
    tick();
    req_valid[0] = 1'b0;
    req_sof[0]   = 1'b0;
    repeat (7) tick();
    n_vec++;
    if (res_valid !== 1'b0) begin
      n_err++;
      $display("FAIL to_early: got res_valid=%b want 0 after 7 stalls", res_valid);
    end
    tick();
    n_vec++;
    if ({res_valid, res_err, res_crc} !== {1'b1, 1'b1, 32'h0}) begin
      n_err++;
      $display("FAIL to_abort: got rv=%b err=%b crc=%h want 1/1/0", res_valid, res_err, res_crc);
    end
    req_valid[0] = 1'b1;
    req_eof[0]   = 1'b1;
    res_ready    = 1'b1;
    tick();
    res_ready    = 1'b0;
    repeat (4) tick();
    n_vec++;
    if ({req_ready, crc_init, res_valid} !== 6'b0) begin
      n_err++;
      $display("FAIL to_leftover: got rdy=%b init=%b rv=%b want 0", req_ready, crc_init,
               res_valid);
    end
    clear_inputs();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    res_ready = 1'b0;
    clear_inputs();
    test_reset();
    test_single_frame();
    test_round_robin();
    test_backpressure();
    test_single_beat();
    test_reset_mid_frame();
`ifdef CR_CRC_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cr_crc_sched.md
Name: cr_crc_sched

Overview:
Frame-level scheduler that shares one cr_crc engine instance among N_REQ streaming requesters.
- Arbitrates round-robin at frame boundaries and holds the grant for the whole frame.
- Initialises the engine, forwards beats, then presents the final CRC with a valid/ready handshake, tagged with the requester id.
- Sits between the per-channel frame sources and the shared CRC datapath.

Parameters:
N_REQ, 4, number of requesters (2..16)
N_DATA_WIDTH, 64, beat width in bits (matches engine)
N_CRC_WIDTH, 32, CRC width (matches engine)
INIT_VALUE, 32'hFFFF_FFFF, value loaded into the engine at frame start
TIMEOUT_CYCLES, 1024, mid-frame stall limit (used only with optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  N_REQ  per-requester beat valid
req_ready  out  N_REQ  per-requester beat accept
req_sof  in  N_REQ  beat is first of frame
req_eof  in  N_REQ  beat is last of frame
req_data  in  N_REQ*N_DATA_WIDTH  beat data, requester i at slice i
req_vbytes  in  N_REQ*8  thermometer byte-valid, requester i at slice i
res_valid  out  1  result valid
res_ready  in  1  result accept
res_crc  out  N_CRC_WIDTH  final CRC
res_id  out  $clog2(N_REQ)  requester owning the result
res_err  out  1  frame aborted (only with optional feature; tied 0 otherwise)
crc_init  out  1  to engine init
crc_init_value  out  N_CRC_WIDTH  to engine init_value, constant INIT_VALUE
crc_data_valid  out  1  to engine data_valid
crc_data_in  out  N_DATA_WIDTH  to engine data_in
crc_data_vbytes  out  8  to engine data_vbytes
crc_enable  out  1  to engine enable
crc_value  in  N_CRC_WIDTH  from engine crc

Behaviour:
- Reset: state IDLE, rr pointer 0, gnt 0; all outputs 0 except crc_init_value. Reset mid-frame drops the frame with no result.
- IDLE:
  - Candidates are i with req_valid[i] & req_sof[i].
  - The rr arbiter picks the first candidate at or after the pointer.
  - Register gnt, set pointer to gnt+1 (mod N_REQ), go INIT.
  - req_ready is all 0; the sof beat is not consumed in IDLE.
  - Valid beats without sof from non-granted requesters are never accepted.
- INIT (1 cycle): crc_init=1, next DATA.
- DATA:
  - req_ready[gnt]=1, all others 0.
  - crc_data_valid=req_valid[gnt]; crc_data_in and crc_data_vbytes come from the gnt slices (combinational pass-through).
  - Mid-frame sof is ignored and treated as data.
  - On an accepted beat with eof, go DONE. Single-beat frames (sof&eof) are legal.
- DONE:
  - crc_enable=1, res_valid=1, res_crc=crc_value, res_id=gnt.
  - The engine holds its value because there is no init or data.
  - On res_ready, go IDLE. The next grant can occur no earlier than the following cycle.
- Outside DONE, crc_enable=0. crc_data_valid and crc_init are never both 1.
- Latency:
  - sof visible to grant: 1 cycle.
  - First beat accepted: 2 cycles after grant, i.e. sof seen in IDLE at cycle t, INIT at t+1, first accept at t+2.
  - eof accepted at t gives res_valid at t+1.
- Frame overhead: 3 cycles (IDLE, INIT, DONE) plus beats plus result backpressure.
- vbytes pass through unchanged. Non-eof beats must be 8'hFF (checked by assertion, not corrected).

Optional Feature:
Macro CR_CRC_SCHED_TIMEOUT_EN.
- Defined:
  - A stall counter runs in DATA. It increments when req_valid[gnt]=0, clears on any accepted beat, and clears in INIT.
  - When it reaches TIMEOUT_CYCLES-1 while stalled, go DONE with res_err=1 and res_crc=0.
  - The remainder of the aborted frame is later seen as non-sof beats and is never accepted.
- Undefined: no counter; res_err tied 0; DATA waits indefinitely.

Decomposition:
- Package cr_crc_sched_pkg:
  - state enum {IDLE, INIT, DATA, DONE}
  - default INIT_VALUE and CRC/data width constants
  - id width function
- Sub-module cr_crc_sched_rr_arb: N_REQ round-robin picker with a registered pointer and an update strobe. Outputs grant index and any-valid.
- Top instantiates the arbiter and the FSM. The engine is instantiated by the parent, not inside this block.

Test Plan:
- Single frame: req 2 sends 3 beats D0..D2, vbytes FF,FF,0F.
  - Expect crc_init at cycle t+1 with value FFFF_FFFF.
  - Expect 3 crc_data_valid pulses carrying D0..D2.
  - Expect res_valid 1 cycle after eof, res_id=2, res_crc equal to the engine model.
- Round-robin: reqs 0, 1, 3 all hold sof at once, pointer 0.
  - Grant order 0, 1, 3.
  - Then a new sof on 0 and 3 gives 0 (pointer wrapped from 3+1 to 0).
- Backpressure: res_ready=0 for 10 cycles.
  - res_valid, res_crc and res_id stay stable.
  - No req_ready asserted.
  - Grant follows one cycle after the handshake.
- Single-beat frame (sof&eof, vbytes 01): INIT, one data cycle, DONE. Total 3 cycles from grant to res_valid.
- Reset mid-frame: rst asserted during DATA.
  - Next cycle all outputs are 0, with no res_valid.
  - A later frame from another requester produces a correct CRC.
- With CR_CRC_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=8: stall after beat 1.
  - res_valid with res_err=1, res_crc=0 after 8 stalled cycles.
  - Leftover beats are never accepted.
